// File: rtl/fpaddsub_exception_status.sv
// Status and trap unit for the FP add/sub exception flags: IEEE sticky bits, a saturating
// count of exception-raising results, and a two-state trap FSM with interrupt and overrun.
module fpaddsub_exception_status #(
    parameter int          CNT_W        = 16,
    parameter logic [4:0]  RESET_ENABLE = 5'b00000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ResValid,
    input  logic [4:0]       Flags,
    input  logic [31:0]      P,
    input  logic             EnWr,
    input  logic [4:0]       EnIn,
    input  logic             Clear,
    input  logic             TrapAck,
    output logic [4:0]       Sticky,
    output logic [4:0]       Enable,
    output logic [CNT_W-1:0] ExcCount,
    output logic             IRQ,
    output logic [4:0]       TrapCause,
    output logic [31:0]      TrapResult,
    output logic             Overrun
);

    typedef enum logic {IDLE, TRAPPED} state_t;

    state_t     state_p1;
    logic [4:0] masked_p0;
    logic       flagged_p0;
    logic       trap_p0;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v)
            return v;
        else
            return v + 1'b1;
    endfunction

    // Trap decision always uses the mask registered at the start of this cycle,
    // so a same-cycle EnWr only affects results from the next cycle on.
    always_comb begin
        masked_p0  = Flags & Enable;
        flagged_p0 = ResValid & (|Flags);
        trap_p0    = ResValid & (|masked_p0);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Sticky     <= '0;
            Enable     <= RESET_ENABLE;
            ExcCount   <= '0;
            IRQ        <= 1'b0;
            TrapCause  <= '0;
            TrapResult <= '0;
            Overrun    <= 1'b0;
            state_p1   <= IDLE;
        end else begin
            // Clear wins over history but never over the result arriving with it.
            Sticky <= (Clear ? 5'b00000 : Sticky) | (ResValid ? Flags : 5'b00000);

            if (Clear)
                ExcCount <= flagged_p0 ? CNT_W'(1) : '0;
            else if (flagged_p0)
                ExcCount <= sat_inc(ExcCount);

            if (EnWr)
                Enable <= EnIn;

            unique case (state_p1)
                IDLE: begin
                    if (trap_p0) begin
                        state_p1   <= TRAPPED;
                        IRQ        <= 1'b1;
                        TrapCause  <= masked_p0;
                        TrapResult <= P;
                    end
                    if (Clear)
                        Overrun <= 1'b0;
                end
                TRAPPED: begin
                    if (TrapAck && trap_p0) begin
                        TrapCause  <= masked_p0;
                        TrapResult <= P;
                    end else if (TrapAck) begin
                        state_p1 <= IDLE;
                        IRQ      <= 1'b0;
                    end
                    // An uncaptured enabled exception beats a simultaneous Clear.
                    if (!TrapAck && trap_p0)
                        Overrun <= 1'b1;
                    else if (Clear)
                        Overrun <= 1'b0;
                end
                default: begin
                    state_p1 <= IDLE;
                    IRQ      <= 1'b0;
                end
            endcase
        end
    end

endmodule
